bounded_step_counter: RTL and testbench
=======================================

Name: bounded_step_counter

Overview:
Sequencing counter that produces the per-step index consumed by the less-than compare stage in the interpolator datapath. On a start request it latches a step limit and emits counts 0..limit-1, one per non-stalled cycle. It flags each valid count, holds under back-pressure, and ends with a single-cycle done pulse. The continue/terminate decision is an unsigned less-than compare of (count+1) against the latched limit.

Parameters:
DATA_WIDTH, 13, width of limit_i and count_o (unsigned)

Ports:
clk_i  input  1  system clock, rising edge
rstn_i  input  1  asynchronous active-low reset
start_i  input  1  start request; accepted only in IDLE
limit_i  input  DATA_WIDTH  number of steps to emit; sampled with accepted start_i
stall_i  input  1  downstream hold; while high, count does not advance and count_valid_o is low
count_o  output  DATA_WIDTH  current step index (registered)
count_valid_o  output  1  count_o is a valid step this cycle
busy_o  output  1  high in RUN and DONE states
done_o  output  1  single-cycle pulse marking end of sequence

Behaviour:
- Reset (async, rstn_i low): state=IDLE, limit_q=0, count_o=0, count_valid_o=0, busy_o=0, done_o=0; takes effect immediately, including mid-sequence; no done pulse is generated for an aborted sequence.
- States: IDLE, RUN, DONE (Moore; busy_o/done_o decoded from registered state).
- IDLE: start_i=1 at edge -> limit_q<=limit_i, count_o<=0; next state RUN if limit_i!=0, else DONE (zero-length sequence, no valid counts).
- RUN: count_valid_o = ~stall_i (combinational from registered state and stall_i).
  - stall_i=1: count_o and state hold.
  - stall_i=0 and (count_o+1) < limit_q: count_o<=count_o+1, stay RUN.
  - stall_i=0 and not (count_o+1) < limit_q: count_o holds at limit_q-1, next DONE.
- DONE: done_o=1 for exactly one cycle, count_valid_o=0, next IDLE unconditionally.
- Compare width: count_o+1 is computed at DATA_WIDTH+1 bits so limit_q=2^DATA_WIDTH-1 terminates correctly; count_o never wraps.
- start_i in RUN or DONE is ignored (not queued); start_i in the IDLE cycle directly after DONE is accepted normally (back-to-back sequences, one IDLE gap cycle).
- limit_i changes during RUN have no effect (only limit_q is used).
- count_o keeps its last value in IDLE until the next accepted start.
- Latency: first valid count appears the cycle after start is accepted. Total cycles from accept to done_o = limit + number of stalled RUN cycles + 1.

Test Plan:
- limit_i=5, start pulse at cycle 0, stall_i=0 -> count_valid_o high cycles 1-5 with count_o 0,1,2,3,4; done_o high at cycle 6 only; busy_o high cycles 1-6.
- limit_i=0, start pulse -> no count_valid_o, done_o high the cycle after start, back to IDLE next cycle.
- limit_i=3, stall_i high during cycle 2 -> valid counts 0 (c1), 1 (c3), 2 (c4); count_o holds 1 in c2; done_o at c5.
- DATA_WIDTH=13, limit_i=8191 -> 8191 valid counts, last count_o=8190, no wrap to 0, one done pulse.
- start_i re-asserted with limit_i=2 during RUN of a limit 4 sequence -> ignored, 4 counts emitted; new start in the IDLE cycle after done -> 2 counts emitted.
- rstn_i driven low mid-RUN at count 2 -> all outputs 0 immediately, no done_o; after release, module in IDLE and accepts a fresh start.

Source files
------------

// File: rtl/bounded_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : bounded_step_counter
// Brief    : Emits step indices 0..limit-1, one per non-stalled cycle, then a
//            single-cycle done pulse. Feeds the interpolator compare stage.
// Revision : 1.0 - initial release
// ============================================================================
module bounded_step_counter #(
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] limit_i,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  count_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH:0]   c_ONE_EXT = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_ZERO    = '0;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_limit;
  logic [DATA_WIDTH-1:0] r_count;

  // The increment is one bit wider than the count so a limit of all-ones
  // still compares correctly and the count never wraps.
  logic [DATA_WIDTH:0]   w_count_inc;
  logic                  w_more;

  assign w_count_inc = {1'b0, r_count} + c_ONE_EXT;
  assign w_more      = (w_count_inc < {1'b0, r_limit});

  // Sequencer: latch limit on accepted start, advance on non-stalled RUN cycles
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_limit <= c_ZERO;
      r_count <= c_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_limit <= limit_i;
            r_count <= c_ZERO;
            r_state <= (limit_i != c_ZERO) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (!stall_i) begin
            if (w_more) begin
              r_count <= w_count_inc[DATA_WIDTH-1:0];
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore status decode; valid is additionally gated by the downstream stall
  always_comb begin
    count_o       = r_count;
    count_valid_o = (r_state == ST_RUN) && !stall_i;
    busy_o        = (r_state == ST_RUN) || (r_state == ST_DONE);
    done_o        = (r_state == ST_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_bounded_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounded_step_counter
// Brief    : Directed self-checking bench for bounded_step_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounded_step_counter;

  localparam int DATA_WIDTH = 13;

  logic                  clk_i;
  logic                  rstn_i;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] limit_i;
  logic                  stall_i;
  logic [DATA_WIDTH-1:0] count_o;
  logic                  count_valid_o;
  logic                  busy_o;
  logic                  done_o;

  int total;
  int bad;

  bounded_step_counter #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .limit_i      (limit_i),
    .stall_i      (stall_i),
    .count_o      (count_o),
    .count_valid_o(count_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic v,
                         input logic b, input logic d);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".valid"}, 32'(count_valid_o), 32'(v));
    chk({tag, ".busy"},  32'(busy_o), 32'(b));
    chk({tag, ".done"},  32'(done_o), 32'(d));
  endtask

  // Advance one clock edge and land on the following negative edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rstn_i  = 1'b0;
    start_i = 1'b0;
    limit_i = '0;
    stall_i = 1'b0;
    #1;
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
    #1 chk_all("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

    // limit 5, no stall: counts 0..4 in cycles 1-5, done in cycle 6
    start_i = 1'b1; limit_i = 13'd5;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk_all($sformatf("l5.c%0d", k + 1), k, 1'b1, 1'b1, 1'b0);
      tick();
    end
    #1 chk_all("l5.done", 4, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("l5.idle", 4, 1'b0, 1'b0, 1'b0);

    // limit 0: straight to DONE, no valid counts
    start_i = 1'b1; limit_i = 13'd0;
    tick();
    start_i = 1'b0;
    #1 chk_all("l0.done", 0, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("l0.idle", 0, 1'b0, 1'b0, 1'b0);

    // limit 3 with a stall during cycle 2
    start_i = 1'b1; limit_i = 13'd3;
    tick();
    start_i = 1'b0;
    #1 chk_all("l3.c1", 0, 1'b1, 1'b1, 1'b0);
    tick();
    stall_i = 1'b1;
    #1 chk_all("l3.c2_stall", 1, 1'b0, 1'b1, 1'b0);
    tick();
    stall_i = 1'b0;
    #1 chk_all("l3.c3", 1, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("l3.c4", 2, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("l3.c5_done", 2, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("l3.idle", 2, 1'b0, 1'b0, 1'b0);

    // Maximum limit: 8191 counts, last is 8190, no wrap
    start_i = 1'b1; limit_i = 13'd8191;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 8191; k++) begin
      #1;
      chk("lmax.count", 32'(count_o), 32'(k));
      chk("lmax.valid", 32'(count_valid_o), 32'd1);
      tick();
    end
    #1 chk_all("lmax.done", 8190, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("lmax.idle", 8190, 1'b0, 1'b0, 1'b0);

    // limit 4, restart attempt mid-RUN ignored; back-to-back start after done
    start_i = 1'b1; limit_i = 13'd4;
    tick();
    start_i = 1'b0;
    #1 chk_all("l4.c1", 0, 1'b1, 1'b1, 1'b0);
    tick();
    start_i = 1'b1; limit_i = 13'd2;
    #1 chk_all("l4.c2", 1, 1'b1, 1'b1, 1'b0);
    tick();
    start_i = 1'b0;
    #1 chk_all("l4.c3", 2, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("l4.c4", 3, 1'b1, 1'b1, 1'b0);
    tick();
    start_i = 1'b1;
    #1 chk_all("l4.done", 3, 1'b0, 1'b1, 1'b1);
    tick();
    start_i = 1'b0;
    #1 chk_all("l4.gap", 3, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1; limit_i = 13'd2;
    tick();
    start_i = 1'b0;
    #1 chk_all("b2b.c1", 0, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("b2b.c2", 1, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("b2b.done", 1, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("b2b.idle", 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset at count 2 aborts without a done pulse
    start_i = 1'b1; limit_i = 13'd5;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #1 chk_all("rst.pre", 2, 1'b1, 1'b1, 1'b0);
    rstn_i = 1'b0;
    #1 chk_all("rst.async", 0, 1'b0, 1'b0, 1'b0);
    tick();
    #1 chk_all("rst.held", 0, 1'b0, 1'b0, 1'b0);
    rstn_i = 1'b1;
    tick();
    #1 chk_all("rst.idle", 0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1; limit_i = 13'd2;
    tick();
    start_i = 1'b0;
    #1 chk_all("post.c1", 0, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("post.c2", 1, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_all("post.done", 1, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_all("post.idle", 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
